vote_session_ctrl: RTL
======================

Name: vote_session_ctrl

Overview:
- Sequences one 4-member voting session: opens a timed ballot window, latches one vote per member, closes, then tallies the yes votes.
- Tally encoding: 0–1 yes = reject (001), 2 = tie (010), 3–4 = pass (100).
- A tie triggers automatic re-vote rounds, up to a limit.
- Sits between the member button front-end (already synchronised, single-cycle pulses) and the result display/LED driver.

Parameters:
- WINDOW_CYCLES, 1000, ballot window length in clk cycles per round (>=2).
- HOLD_CYCLES, 500, cycles the final result is held valid before return to idle (>=1).
- MAX_REVOTE, 2, maximum extra rounds after a tie (0..3).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; opens a session (honoured only in IDLE).
- btn_yes  in  4  per-member yes pulse; bit i = member i.
- btn_no  in  4  per-member no pulse; bit i = member i.
- busy  out  1  high in any state except IDLE.
- voting_open  out  1  high in OPEN.
- voted  out  4  bit i set once member i's vote is locked this round.
- round  out  2  current round index, 0 = first ballot.
- result  out  3  one-hot: 001 reject, 010 tie, 100 pass; 000 when not valid.
- result_valid  out  1  high in SHOW.
- timeout_flag  out  1  sticky per session: some round closed by timer with voted != 4'hF.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, timer=0, hold counter=0.
  - Outputs: voted=0, yes register=0, round=0, result=000, result_valid=0, timeout_flag=0, busy=0, voting_open=0.
  - Reset mid-session aborts immediately; no result is produced.
- States: IDLE, OPEN, EVAL, SHOW. All outputs are registered.
- IDLE:
  - On start=1, next edge enters OPEN with voted=0, yes=0, timer=0, round=0, timeout_flag=0.
- OPEN:
  - Per member i with voted[i]=0:
    - btn_yes[i]^btn_no[i]=1 → voted[i]<=1, yes[i]<=btn_yes[i].
    - Both set in the same cycle → ignored; member stays unvoted.
  - Presses from an already-voted member are ignored (no vote change).
  - Timer increments each OPEN cycle.
  - Exit to EVAL at the next edge when registered voted==4'hF, or when timer==WINDOW_CYCLES-1.
  - Votes presented in the timer-expiry cycle are still accepted.
  - On timer exit with voted (after that cycle's accepts) != 4'hF, set timeout_flag.
  - Unvoted members count as no.
- Latency: last vote locks at edge k → state=EVAL after edge k+1 → result/result_valid visible after edge k+2.
- EVAL (exactly 1 cycle): n = popcount(yes).
  - n==2 and round<MAX_REVOTE → round<=round+1, voted<=0, yes<=0, timer<=0, back to OPEN.
  - Otherwise → result<=one-hot(n), result_valid<=1, hold counter=0, go to SHOW.
  - A final tie (round==MAX_REVOTE) is reported as 010.
- SHOW:
  - Hold counter increments; at HOLD_CYCLES-1 the next edge returns to IDLE.
  - On that return: result<=000, result_valid<=0.
  - round, voted and timeout_flag keep their values until the next start.
- start is ignored in OPEN, EVAL and SHOW.
- start in the same cycle as the SHOW→IDLE transition is ignored; it must be re-issued in IDLE.
- btn inputs are ignored outside OPEN.
- Counters: timer width clog2(WINDOW_CYCLES); hold counter width clog2(HOLD_CYCLES). Neither may wrap within a round.

Test Plan:
- Reset check: assert rst_n=0 mid-OPEN with two votes locked → all outputs zero and state IDLE immediately; rst_n=1 then start → fresh session, round=0.
- Full early pass: start, yes from members 0,1,2 and no from member 3 on consecutive cycles → EVAL one edge after voted=F; result=100, result_valid=1 two edges after the last vote; held HOLD_CYCLES; then result=000, busy=0; timeout_flag=0.
- Timeout reject: start, only member 2 votes yes, no further input → close at WINDOW_CYCLES; result=001, timeout_flag=1, voted=0100.
- Tie re-vote chain (MAX_REVOTE=2):
  - Rounds 0 and 1 each vote 1100 yes → round increments to 1, then 2; voted cleared each time.
  - Round 2 votes 1110 → result=100, round=2.
  - Separate run with a tie in all three rounds → result=010.
- Input conflicts: same-cycle yes+no for member 1 → not locked; a later yes locks it. A second press (no) after a yes lock → ignored, tally unchanged. Vote in the exact expiry cycle → counted.
- Ignored start: start pulses during OPEN and SHOW → no state/round/timer disturbance; start in IDLE after SHOW → new session.

Source files
------------

// File: rtl/vote_session_ctrl.sv
// Four-member voting session sequencer: timed ballot window, one locked vote per member,
// tally to reject/tie/pass one-hot, automatic re-vote rounds on a tie, then a held result.
module vote_session_ctrl #(
   parameter int WINDOW_CYCLES = 1000,
   parameter int HOLD_CYCLES   = 500,
   parameter int MAX_REVOTE    = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] btn_yes,
   input  logic [3:0] btn_no,
   output logic       busy,
   output logic       voting_open,
   output logic [3:0] voted,
   output logic [1:0] round,
   output logic [2:0] result,
   output logic       result_valid,
   output logic       timeout_flag
);

   localparam int TW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [TW-1:0] TMAX = TW'(WINDOW_CYCLES - 1);
   localparam logic [HW-1:0] HMAX = HW'(HOLD_CYCLES - 1);
   localparam logic [1:0]    RMAX = 2'(MAX_REVOTE);

   typedef enum logic [1:0] {S_IDLE, S_OPEN, S_EVAL, S_SHOW} state_t;

   state_t          r_state, w_state_nx;
   logic [TW-1:0]   r_timer, w_timer_nx;
   logic [HW-1:0]   r_hold, w_hold_nx;
   logic [3:0]      r_voted, w_voted_nx;
   logic [3:0]      r_yes, w_yes_nx;
   logic [1:0]      r_round, w_round_nx;
   logic [2:0]      r_result, w_result_nx;
   logic            r_valid, w_valid_nx;
   logic            r_timeout, w_timeout_nx;
   logic [3:0]      w_accept;
   logic [2:0]      w_yes_cnt;

   function automatic logic [2:0] f_popcount(input logic [3:0] v);
      return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
   endfunction

   function automatic logic [2:0] f_tally(input logic [2:0] n);
      if (n <= 3'd1)      return 3'b001;
      else if (n == 3'd2) return 3'b010;
      else                return 3'b100;
   endfunction

   // A member locks only with exactly one of yes/no asserted and only once per round.
   assign w_accept  = ~r_voted & (btn_yes ^ btn_no);
   assign w_yes_cnt = f_popcount(r_yes);

   always_comb begin
      w_state_nx   = r_state;
      w_timer_nx   = r_timer;
      w_hold_nx    = r_hold;
      w_voted_nx   = r_voted;
      w_yes_nx     = r_yes;
      w_round_nx   = r_round;
      w_result_nx  = r_result;
      w_valid_nx   = r_valid;
      w_timeout_nx = r_timeout;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nx   = S_OPEN;
               w_voted_nx   = 4'h0;
               w_yes_nx     = 4'h0;
               w_timer_nx   = '0;
               w_round_nx   = 2'd0;
               w_timeout_nx = 1'b0;
            end
         end
         S_OPEN: begin
            w_voted_nx = r_voted | w_accept;
            w_yes_nx   = r_yes | (w_accept & btn_yes);
            if (r_voted == 4'hF) begin
               w_state_nx = S_EVAL;
            end else if (r_timer == TMAX) begin
               // Expiry-cycle votes still count before deciding whether the timer closed early.
               w_state_nx = S_EVAL;
               if ((r_voted | w_accept) != 4'hF) w_timeout_nx = 1'b1;
            end else begin
               w_timer_nx = r_timer + 1'b1;
            end
         end
         S_EVAL: begin
            if (w_yes_cnt == 3'd2 && r_round < RMAX) begin
               w_state_nx = S_OPEN;
               w_round_nx = r_round + 2'd1;
               w_voted_nx = 4'h0;
               w_yes_nx   = 4'h0;
               w_timer_nx = '0;
            end else begin
               w_state_nx  = S_SHOW;
               w_result_nx = f_tally(w_yes_cnt);
               w_valid_nx  = 1'b1;
               w_hold_nx   = '0;
            end
         end
         S_SHOW: begin
            if (r_hold == HMAX) begin
               w_state_nx  = S_IDLE;
               w_result_nx = 3'b000;
               w_valid_nx  = 1'b0;
            end else begin
               w_hold_nx = r_hold + 1'b1;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_timer   <= '0;
         r_hold    <= '0;
         r_voted   <= 4'h0;
         r_yes     <= 4'h0;
         r_round   <= 2'd0;
         r_result  <= 3'b000;
         r_valid   <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_timer   <= w_timer_nx;
         r_hold    <= w_hold_nx;
         r_voted   <= w_voted_nx;
         r_yes     <= w_yes_nx;
         r_round   <= w_round_nx;
         r_result  <= w_result_nx;
         r_valid   <= w_valid_nx;
         r_timeout <= w_timeout_nx;
      end
   end

   assign busy         = (r_state != S_IDLE);
   assign voting_open  = (r_state == S_OPEN);
   assign voted        = r_voted;
   assign round        = r_round;
   assign result       = r_result;
   assign result_valid = r_valid;
   assign timeout_flag = r_timeout;

endmodule
